dq_clear_buffer: RTL and testbench

- Producer side of the dataQue clear interface.
- Collects per-cycle completion writebacks from up to WBPORT_NUM execution writeback ports and funnels them onto the CLEARPORT_NUM clear ports of a dataQue (ROB, imm buffer, branch buffer).
- Execution units cannot stall, so overflow is buffered in a multi-in/multi-out circular FIFO.
- A throttle signal to issue prevents the FIFO from filling.

---
 rtl/dq_clear_buffer_pkg.sv | 26 ++
 rtl/dq_clear_compact.sv | 40 ++++
 rtl/dq_clear_buffer.sv | 126 ++++++++++++
 tb/tb_dq_clear_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dq_clear_buffer_pkg.sv
// Shared types and default sizing for the dataQue clear path.
// count_one is the common population-count helper used by multi-port writers.
package dq_clear_buffer_pkg;

  localparam int DQ_DEPTH              = 30;
  localparam int IDX_W                 = $clog2(DQ_DEPTH);
  localparam int WBPORT_NUM            = 6;
  localparam int CLEARPORT_NUM         = 4;
  localparam int DQ_CLEAR_FIFO_DEPTH   = 16;
  localparam int DQ_CLEAR_THROTTLE_LVL = 6;

  typedef logic [IDX_W-1:0] dqIdx_t;

  typedef struct packed {
    logic   vld;
    dqIdx_t dqIdx;
  } clear_req_t;

  function automatic logic [5:0] count_one(input logic [31:0] bits);
    logic [5:0] ones;
    ones = '0;
    for (int i = 0; i < 32; i++) ones = ones + 6'(bits[i]);
    return ones;
  endfunction

endpackage

// File: rtl/dq_clear_compact.sv
// Combinational packer: squeezes sparse valid lanes into contiguous slots
// starting at slot 0, preserving ascending port order, and reports how many.
module dq_clear_compact
  import dq_clear_buffer_pkg::*;
#(
  parameter int PORT_NUM = 6,
  parameter int W        = 5
) (
  input  logic [PORT_NUM-1:0]                         in_vld,
  input  logic [PORT_NUM-1:0][W-1:0]                  in_idx,
  output logic [PORT_NUM-1:0]                         out_vld,
  output logic [PORT_NUM-1:0][W-1:0]                  out_idx,
  output logic [$clog2(PORT_NUM+1)-1:0]               num
);

  localparam int CNT_W = $clog2(PORT_NUM+1);

  logic [CNT_W-1:0] pos;

  assign num = CNT_W'(count_one(32'(in_vld)));

  // Running prefix sum: each valid lane lands in the slot equal to the
  // number of valid lanes below it.
  always_comb begin
    out_idx = '0;
    pos     = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (in_vld[i]) begin
        out_idx[pos] = in_idx[i];
        pos          = pos + 1'b1;
      end
    end
  end

  always_comb begin
    out_vld = '0;
    for (int j = 0; j < PORT_NUM; j++) out_vld[j] = (j < int'(num));
  end

endmodule

// File: rtl/dq_clear_buffer.sv
// Funnels sparse execution writebacks onto the dataQue clear ports through a
// multi-in/multi-out FIFO. Define DQ_CLEAR_BYPASS_EN for zero-cycle bypass.
module dq_clear_buffer
  import dq_clear_buffer_pkg::*;
#(
  parameter int DQ_DEPTH      = dq_clear_buffer_pkg::DQ_DEPTH,
  parameter int WBPORT_NUM    = dq_clear_buffer_pkg::WBPORT_NUM,
  parameter int CLEARPORT_NUM = dq_clear_buffer_pkg::CLEARPORT_NUM,
  parameter int FIFO_DEPTH    = DQ_CLEAR_FIFO_DEPTH,
  parameter int THROTTLE_LVL  = DQ_CLEAR_THROTTLE_LVL,
  localparam int IDX_W        = $clog2(DQ_DEPTH),
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_flush,
  input  logic [WBPORT_NUM-1:0]                   i_wb_vld,
  input  logic [WBPORT_NUM-1:0][IDX_W-1:0]        i_wb_dqIdx,
  output logic [CLEARPORT_NUM-1:0]                o_clear_vld,
  output logic [CLEARPORT_NUM-1:0][IDX_W-1:0]     o_clear_dqIdx,
  output logic                                    o_throttle,
  output logic [CNT_W-1:0]                        o_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int SEL_W  = $clog2(WBPORT_NUM);
  localparam int WCNT_W = $clog2(WBPORT_NUM + 1);

  logic [IDX_W-1:0]                 mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                 head;
  logic [PTR_W-1:0]                 tail;
  logic [CNT_W-1:0]                 count;
  logic [WBPORT_NUM-1:0]            cmp_vld;
  logic [WBPORT_NUM-1:0][IDX_W-1:0] cmp_idx;
  logic [WCNT_W-1:0]                n;
  logic                             overflow;
  int                               d;
  int                               byp;
  int                               enq;
  int                               room;
  int                               enq_eff;
  int                               count_next;
`ifdef DQ_CLEAR_BYPASS_EN
  int                               r;
`endif

  dq_clear_compact #(
    .PORT_NUM (WBPORT_NUM),
    .W        (IDX_W)
  ) u_compact (
    .in_vld  (i_wb_vld),
    .in_idx  (i_wb_dqIdx),
    .out_vld (cmp_vld),
    .out_idx (cmp_idx),
    .num     (n)
  );

  assign o_count = count;

  // Drain first, then bypass into leftover ports, then enqueue the rest;
  // anything that does not fit is dropped so the pointers stay consistent.
  always_comb begin
    d = (int'(count) < CLEARPORT_NUM) ? int'(count) : CLEARPORT_NUM;
`ifdef DQ_CLEAR_BYPASS_EN
    r   = CLEARPORT_NUM - d;
    byp = (int'(n) < r) ? int'(n) : r;
`else
    byp = 0;
`endif
    enq        = int'(n) - byp;
    room       = FIFO_DEPTH - int'(count) + d;
    overflow   = enq > room;
    enq_eff    = overflow ? room : enq;
    count_next = int'(count) - d + enq_eff;
  end

  always_comb begin
    o_clear_vld   = '0;
    o_clear_dqIdx = '0;
    for (int p = 0; p < CLEARPORT_NUM; p++) begin
      if (p < d) begin
        o_clear_vld[p]   = 1'b1;
        o_clear_dqIdx[p] = mem[PTR_W'(int'(head) + p)];
      end
`ifdef DQ_CLEAR_BYPASS_EN
      else if ((p - d) < byp) begin
        o_clear_vld[p]   = 1'b1;
        o_clear_dqIdx[p] = cmp_idx[SEL_W'(p - d)];
      end
`endif
    end
    if (rst || i_flush) o_clear_vld = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && !i_flush) begin
      for (int k = 0; k < WBPORT_NUM; k++) begin
        if (k < enq_eff && cmp_vld[SEL_W'(k + byp)])
          mem[PTR_W'(int'(tail) + k)] <= cmp_idx[SEL_W'(k + byp)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      o_throttle <= 1'b0;
    end else begin
      head       <= PTR_W'(int'(head) + d);
      tail       <= PTR_W'(int'(tail) + enq_eff);
      count      <= CNT_W'(count_next);
      o_throttle <= (FIFO_DEPTH - count_next) < THROTTLE_LVL;
    end
  end

`ifndef SYNTHESIS
  // Issue throttling should make this unreachable; hitting it loses clears.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush)
      assert (!overflow) else $error("dq_clear_buffer: writeback overflow, %0d entries dropped", enq - room);
  end
`endif

endmodule

// File: tb/tb_dq_clear_buffer.sv
// Directed, table-driven bench for dq_clear_buffer.
// Expectations follow DQ_CLEAR_BYPASS_EN when it is defined for the build.
module tb_dq_clear_buffer;

  localparam int IDX_W = 5;
  localparam int WB    = 6;
  localparam int CP    = 4;
  localparam int CNT_W = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     i_flush = 1'b0;
  logic [WB-1:0]            i_wb_vld = '0;
  logic [WB-1:0][IDX_W-1:0] i_wb_dqIdx = '0;
  logic [CP-1:0]            o_clear_vld;
  logic [CP-1:0][IDX_W-1:0] o_clear_dqIdx;
  logic                     o_throttle;
  logic [CNT_W-1:0]         o_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic                     rst;
    logic                     flush;
    logic [WB-1:0]            vld;
    logic [WB-1:0][IDX_W-1:0] idx;
    logic [CP-1:0]            ev;
    logic [CP-1:0][IDX_W-1:0] eidx;
    int                       ecnt;
    logic                     ethr;
    bit                       chkclr;
  } vec_t;

  vec_t tbl[$];

  dq_clear_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (i_flush),
    .i_wb_vld      (i_wb_vld),
    .i_wb_dqIdx    (i_wb_dqIdx),
    .o_clear_vld   (o_clear_vld),
    .o_clear_dqIdx (o_clear_dqIdx),
    .o_throttle    (o_throttle),
    .o_count       (o_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic f, input logic [WB-1:0] v,
                              input int i0, input int i1, input int i2, input int i3,
                              input int i4, input int i5, input logic [CP-1:0] ev,
                              input int e0, input int e1, input int e2, input int e3,
                              input int c, input logic t, input bit chk);
    vec_t m;
    int   ia[WB];
    int   ea[CP];
    ia = '{i0, i1, i2, i3, i4, i5};
    ea = '{e0, e1, e2, e3};
    m.rst    = r;
    m.flush  = f;
    m.vld    = v;
    m.ev     = ev;
    m.ecnt   = c;
    m.ethr   = t;
    m.chkclr = chk;
    for (int k = 0; k < WB; k++) m.idx[k] = IDX_W'(ia[k]);
    for (int k = 0; k < CP; k++) m.eidx[k] = IDX_W'(ea[k]);
    return m;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    i_flush    = v.flush;
    i_wb_vld   = v.vld;
    i_wb_dqIdx = v.idx;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int step);
    if (v.chkclr) begin
      total++;
      if (o_clear_vld !== v.ev) begin
        bad++;
        $display("[TB] FAIL %s[%0d] clear_vld got=%b want=%b", tag, step, o_clear_vld, v.ev);
      end
      for (int p = 0; p < CP; p++) begin
        if (v.ev[p]) begin
          total++;
          if (o_clear_dqIdx[p] !== v.eidx[p]) begin
            bad++;
            $display("[TB] FAIL %s[%0d] clear_idx%0d got=%0d want=%0d", tag, step, p, o_clear_dqIdx[p], v.eidx[p]);
          end
        end
      end
    end
    total++;
    if (o_count !== CNT_W'(v.ecnt)) begin
      bad++;
      $display("[TB] FAIL %s[%0d] count got=%0d want=%0d", tag, step, o_count, v.ecnt);
    end
    total++;
    if (o_throttle !== v.ethr) begin
      bad++;
      $display("[TB] FAIL %s[%0d] throttle got=%b want=%b", tag, step, o_throttle, v.ethr);
    end
  endtask

  task automatic runVec(input vec_t v, input string tag, input int step);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v, tag, step);
  endtask

  task automatic runTable(input string tag);
    for (int s = 0; s < tbl.size(); s++) runVec(tbl[s], tag, s);
    tbl.delete();
  endtask

`ifdef DQ_CLEAR_BYPASS_EN
  int fill_c[6]  = '{0, 2, 4, 6, 8, 10};
  bit fill_t[6]  = '{0, 0, 0, 0, 0, 0};
  int drain_c[5] = '{12, 8, 4, 0, 0};
  bit drain_t[5] = '{1, 0, 0, 0, 0};
`else
  int fill_c[6]  = '{0, 6, 8, 10, 12, 14};
  bit fill_t[6]  = '{0, 0, 0, 0, 1, 1};
  int drain_c[5] = '{16, 12, 8, 4, 0};
  bit drain_t[5] = '{1, 1, 0, 0, 0};
`endif

  initial begin
    $display("[TB] start");

    runVec(mk(1, 0, 6'h3F, 1, 2, 3, 4, 5, 6, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "reset", 0);

`ifdef DQ_CLEAR_BYPASS_EN
    tbl.push_back(mk(0, 0, 6'b000101, 3, 0, 7, 0, 0, 0, 4'b0011, 3, 7, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b111111, 0, 1, 2, 3, 4, 5, 4'b1111, 0, 1, 2, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0011, 4, 5, 0, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b111111, 0, 1, 2, 3, 4, 5, 4'b1111, 0, 1, 2, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b010011, 9, 10, 0, 0, 11, 0, 4'b1111, 4, 5, 9, 10, 2, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0001, 11, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
`else
    tbl.push_back(mk(0, 0, 6'b000101, 3, 0, 7, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0011, 3, 7, 0, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 6'b111111, 0, 1, 2, 3, 4, 5, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 1, 2, 3, 6, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0011, 4, 5, 0, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 6'b111111, 0, 1, 2, 3, 4, 5, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 6'b010011, 9, 10, 0, 0, 11, 0, 4'b1111, 0, 1, 2, 3, 6, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b1111, 4, 5, 9, 10, 5, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0001, 11, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
`endif
    runTable("basic");

    // Throttle: saturate the writeback ports, then let the queue drain.
    for (int c = 0; c < 6; c++)
      runVec(mk(0, 0, 6'h3F, 0, 1, 2, 3, 4, 5, 4'b0000, 0, 0, 0, 0, fill_c[c], fill_t[c], 0), "throttle_fill", c);
    for (int c = 0; c < 5; c++)
      runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, drain_c[c], drain_t[c], 0), "throttle_drain", c);

    // Flush with five pending entries and a full set of incoming writebacks.
`ifdef DQ_CLEAR_BYPASS_EN
    runVec(mk(0, 0, 6'h3F, 0, 1, 2, 3, 4, 5, 4'b1111, 0, 1, 2, 3, 0, 0, 1), "flush", 0);
    runVec(mk(0, 0, 6'h3F, 6, 7, 8, 9, 10, 11, 4'b1111, 4, 5, 6, 7, 2, 0, 1), "flush", 1);
    runVec(mk(0, 0, 6'h1F, 12, 13, 14, 15, 16, 0, 4'b1111, 8, 9, 10, 11, 4, 0, 1), "flush", 2);
`else
    runVec(mk(0, 0, 6'h1F, 0, 1, 2, 3, 4, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "flush", 2);
`endif
    runVec(mk(0, 1, 6'h3F, 20, 21, 22, 23, 24, 25, 4'b0000, 0, 0, 0, 0, 5, 0, 1), "flush", 3);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "flush", 4);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "flush", 5);

    // Reset mid-operation, asserted together with flush.
`ifdef DQ_CLEAR_BYPASS_EN
    runVec(mk(0, 0, 6'h3F, 1, 2, 3, 4, 5, 6, 4'b1111, 1, 2, 3, 4, 0, 0, 1), "midreset", 0);
    runVec(mk(1, 1, 6'h3F, 7, 8, 9, 10, 11, 12, 4'b0000, 0, 0, 0, 0, 2, 0, 1), "midreset", 1);
`else
    runVec(mk(0, 0, 6'h07, 1, 2, 3, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "midreset", 0);
    runVec(mk(1, 1, 6'h3F, 7, 8, 9, 10, 11, 12, 4'b0000, 0, 0, 0, 0, 3, 0, 1), "midreset", 1);
`endif
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "midreset", 2);

    // Walk head to 14 from a clean pointer state, then drain across the wrap.
`ifdef DQ_CLEAR_BYPASS_EN
    for (int j = 0; j < 7; j++) begin
      runVec(mk(0, 0, 6'h3F, (6*j)%30, (6*j+1)%30, (6*j+2)%30, (6*j+3)%30, (6*j+4)%30, (6*j+5)%30,
                4'b1111, (6*j)%30, (6*j+1)%30, (6*j+2)%30, (6*j+3)%30, 0, 0, 1), "walk", 2*j);
      runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0011, (6*j+4)%30, (6*j+5)%30, 0, 0, 2, 0, 1), "walk", 2*j+1);
    end
    runVec(mk(0, 0, 6'h3F, 20, 21, 22, 23, 24, 25, 4'b1111, 20, 21, 22, 23, 0, 0, 1), "wrap", 0);
    runVec(mk(0, 0, 6'h3F, 26, 27, 28, 29, 0, 1, 4'b1111, 24, 25, 26, 27, 2, 0, 1), "wrap", 1);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b1111, 28, 29, 0, 1, 4, 0, 1), "wrap", 2);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "wrap", 3);
`else
    for (int i = 0; i < 7; i++)
      runVec(mk(0, 0, 6'b000011, 2*i, 2*i+1, 0, 0, 0, 0, (i == 0) ? 4'b0000 : 4'b0011,
                (i == 0) ? 0 : 2*i-2, (i == 0) ? 0 : 2*i-1, 0, 0, (i == 0) ? 0 : 2, 0, 1), "walk", i);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0011, 12, 13, 0, 0, 2, 0, 1), "walk", 7);
    runVec(mk(0, 0, 6'h3F, 20, 21, 22, 23, 24, 25, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "wrap", 0);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b1111, 20, 21, 22, 23, 6, 0, 1), "wrap", 1);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0011, 24, 25, 0, 0, 2, 0, 1), "wrap", 2);
    runVec(mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1), "wrap", 3);
`endif

    @(negedge clk);
    i_wb_vld = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
